// File: rtl/cchw_led_pkg.sv
// Shared constants and types for the LED-count scheduler slice.
package cchw_led_pkg;

    localparam int W_DEF       = 6;   // whole bits of an amplitude
    localparam int D_DEF       = 10;  // fractional bits of an amplitude
    localparam int LEDS_DEF    = 50;  // LEDs on the strip
    localparam int LEDS_X_DEF  = 20;  // 1/LEDS in 0.D fixed point
    localparam int BIN_QTY_DEF = 12;  // note bins per frame

    // Width of one per-bin count and of the running total (total may equal LEDS).
    localparam int CNT_W_DEF = $clog2(LEDS_DEF);
    localparam int TOT_W_DEF = CNT_W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE,
        THRESH,
        LOAD,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// quotient/done are presented combinationally in the cycle that computes
// the final bit, so the caller can consume the result on that same edge.
module serial_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         done
);

    localparam int IW = $clog2(N + 1);

    logic          run;
    logic [IW-1:0] iter;
    logic [N-1:0]  dq;       // dividend shifting out, quotient shifting in
    logic [N-1:0]  dvs;
    logic [N-1:0]  rem;      // partial remainder, always < divisor

    logic [N:0]    rem_sh;
    logic [N:0]    rem_sub;
    logic [N:0]    rem_sel;
    logic          q_bit;
    logic [N-1:0]  dq_nxt;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh   = {rem, dq[N-1]};
        rem_sub  = rem_sh - {1'b0, dvs};
        q_bit    = (rem_sh >= {1'b0, dvs});
        rem_sel  = q_bit ? rem_sub : rem_sh;
        dq_nxt   = {dq[N-2:0], q_bit};
        quotient = dq_nxt;
        done     = run && (iter == IW'(N - 1));
    end

    // Iteration state; load restarts from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= 1'b0;
            iter <= '0;
            dq   <= '0;
            dvs  <= '0;
            rem  <= '0;
        end else if (load) begin
            run  <= 1'b1;
            iter <= '0;
            dq   <= dividend;
            dvs  <= divisor;
            rem  <= '0;
        end else if (run) begin
            dq   <= dq_nxt;
            rem  <= N'(rem_sel);
            iter <= iter + IW'(1);
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/led_count_scheduler.sv
// Per-frame LED count allocation: threshold = sum/LEDS, then each bin's
// amplitude is divided by the threshold on one shared serial divider.
// Counts are clamped so the running total never exceeds LEDS; lower bins
// are served first and therefore win when the strip runs out.
module led_count_scheduler
    import cchw_led_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int D       = D_DEF,
    parameter int LEDS    = LEDS_DEF,
    parameter int LEDS_X  = LEDS_X_DEF,
    parameter int BIN_QTY = BIN_QTY_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [BIN_QTY-1:0][W+D-1:0]            noteAmplitudes_i,
    input  logic [W+D+$clog2(BIN_QTY)-1:0]         amplitudeSumNew_i,
    output logic                                   busy,
    output logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]   LEDCount,
    output logic [$clog2(LEDS):0]                  ledTotal,
    output logic                                   data_v
);

    localparam int N  = W + D;
    localparam int SW = W + D + $clog2(BIN_QTY);
    localparam int CW = $clog2(LEDS);
    localparam int TW = CW + 1;
    localparam int IW = $clog2(BIN_QTY + 1);

    state_t                       state, state_nxt;

    logic [BIN_QTY-1:0][N-1:0]    amp_q;
    logic [SW-1:0]                sum_q;
    logic [N-1:0]                 thr_q;
    logic [IW-1:0]                idx;
    logic [TW-1:0]                total;
    logic [BIN_QTY-1:0][CW-1:0]   cnt_q;

    logic [SW-1:0]                thr_full;
    logic [N-1:0]                 thr_c;
    logic                         div_load;
    logic                         div_done;
    logic [N-1:0]                 div_q;
    logic [CW-1:0]                q_sat;
    logic [TW-1:0]                room;
    logic [CW-1:0]                cnt_new;
    logic [BIN_QTY-1:0][CW-1:0]   cnt_nxt;
    logic [TW-1:0]                total_nxt;
    logic                         last_bin;

    serial_divider #(.N(N)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (amp_q[idx]),
        .divisor  (thr_q),
        .quotient (div_q),
        .done     (div_done)
    );

    // Threshold from captured sum, saturated into W.D; clamp bookkeeping.
    always_comb begin
        thr_full  = SW'(((SW+D)'(sum_q) * (SW+D)'(LEDS_X)) >> D);
        thr_c     = (|thr_full[SW-1:N]) ? '1 : thr_full[N-1:0];
        q_sat     = (div_q > N'(LEDS)) ? CW'(LEDS) : div_q[CW-1:0];
        room      = TW'(LEDS) - total;
        cnt_new   = ({1'b0, q_sat} > room) ? room[CW-1:0] : q_sat;
        last_bin  = (idx == IW'(BIN_QTY - 1));
        cnt_nxt   = cnt_q;
        total_nxt = total;
        if (state == DIV && div_done) begin
            cnt_nxt[idx] = cnt_new;
            total_nxt    = total + TW'(cnt_new);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt = state;
        div_load  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:   if (start) state_nxt = THRESH;
            THRESH: state_nxt = (thr_c == '0) ? DONE : LOAD;
            LOAD: begin
                div_load  = 1'b1;
                state_nxt = DIV;
            end
            DIV:    if (div_done) state_nxt = last_bin ? DONE : LOAD;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame capture and per-bin accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amp_q <= '0;
            sum_q <= '0;
            thr_q <= '0;
            idx   <= '0;
            total <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    amp_q <= noteAmplitudes_i;
                    sum_q <= amplitudeSumNew_i;
                    idx   <= '0;
                    total <= '0;
                    cnt_q <= '0;
                end
                THRESH: thr_q <= thr_c;
                DIV: if (div_done) begin
                    cnt_q <= cnt_nxt;
                    total <= total_nxt;
                    idx   <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Published results: loaded on the edge into DONE, so they are valid
    // alongside data_v and hold until the next frame finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LEDCount <= '0;
            ledTotal <= '0;
            data_v   <= 1'b0;
        end else begin
            data_v <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                LEDCount <= cnt_nxt;
                ledTotal <= total_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_count_scheduler.sv
// Self-checking bench for led_count_scheduler: directed table, multi-cycle
// corner sequences, and randomized frames against an arithmetic model.
module tb_led_count_scheduler;

    localparam int BQ   = 12;
    localparam int AW   = 16;
    localparam int SW   = 20;
    localparam int CW   = 6;
    localparam int TW   = 7;
    localparam int LEDS = 50;
    localparam int NOM_LAT = 206;

    typedef logic [BQ-1:0][AW-1:0] amps_t;
    typedef logic [BQ-1:0][CW-1:0] cnts_t;

    typedef struct {
        amps_t         a;
        logic [SW-1:0] s;
        cnts_t         c;
        int            tot;
        int            lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    amps_t         amp = '0;
    logic [SW-1:0] sum = '0;
    logic          busy;
    cnts_t         LEDCount;
    logic [TW-1:0] ledTotal;
    logic          data_v;

    int checks = 0;
    int failures = 0;

    led_count_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .noteAmplitudes_i  (amp),
        .amplitudeSumNew_i (sum),
        .busy              (busy),
        .LEDCount          (LEDCount),
        .ledTotal          (ledTotal),
        .data_v            (data_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: threshold = floor(sum*LEDS_X / 2^D), saturated to 16 bits;
    // each bin gets floor(amp/thr) capped at LEDS and at what is left.
    function automatic void model(input amps_t a, input logic [SW-1:0] s,
                                  output cnts_t c, output int tot, output int lat);
        longint thr;
        longint q;
        thr = (longint'(s) * 20) / 1024;
        if (thr > 65535) thr = 65535;
        c = '0;
        tot = 0;
        lat = (thr == 0) ? 2 : NOM_LAT;
        if (thr == 0) return;
        for (int i = 0; i < BQ; i++) begin
            q = longint'(a[i]) / thr;
            if (q > LEDS) q = LEDS;
            if (q > LEDS - tot) q = LEDS - tot;
            c[i] = CW'(q);
            tot += int'(q);
        end
    endfunction

    // Runs one frame. Latency counts edges with the accepting edge as 1.
    // Optionally pulses start again with other amplitudes at edge mid_at.
    task automatic run_frame(input amps_t a, input logic [SW-1:0] s,
                             input int mid_at, input amps_t a2,
                             output cnts_t gc, output int gt, output int lat,
                             output bit busy_ok, output bit pulse_ok);
        int n;
        busy_ok = 1;
        pulse_ok = 1;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        amp = a;
        sum = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!data_v && lat < 1000) begin
            if (!busy) busy_ok = 0;
            if (lat == mid_at) begin
                amp = a2;
                sum = s + 20'd3000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        gc = LEDCount;
        gt = int'(ledTotal);
        @(negedge clk);
        if (data_v) pulse_ok = 0;
    endtask

    task automatic check_frame(input string tag, input cnts_t gc, input int gt,
                               input int lat, input bit bok, input bit pok,
                               input cnts_t ec, input int et, input int el);
        for (int i = 0; i < BQ; i++)
            chk($sformatf("%s cnt[%0d]", tag, i), longint'(gc[i]), longint'(ec[i]));
        chk({tag, " total"}, gt, et);
        chk({tag, " latency"}, lat, el);
        chk({tag, " busy_held"}, bok, 1);
        chk({tag, " single_pulse"}, pok, 1);
    endtask

    initial begin
        vec_t  tbl[5];
        amps_t nom_a;
        amps_t alt_a;
        cnts_t nom_c;
        cnts_t gc;
        cnts_t ec;
        int    gt, lat, et, el, cyc, prev, seen, dbl;
        int    tstamp[3];
        bit    bok, pok, prev_v;

        nom_a = '0;
        nom_a[0] = 16'd3402; nom_a[6] = 16'd3402; nom_a[8] = 16'd3402; nom_a[5] = 16'd330;
        nom_c = '0;
        nom_c[0] = 6'd16; nom_c[6] = 6'd16; nom_c[8] = 6'd16; nom_c[5] = 6'd1;
        alt_a = '0;
        for (int i = 0; i < BQ; i++) alt_a[i] = 16'd5000;

        tbl[0] = '{a: nom_a, s: 20'd10536, c: nom_c, tot: 49, lat: NOM_LAT};
        tbl[1] = '{a: '0, s: 20'd1024, c: '0, tot: 50, lat: NOM_LAT};
        tbl[1].a[0] = 16'd1000; tbl[1].a[1] = 16'd1000; tbl[1].a[2] = 16'd200;
        tbl[1].c[0] = 6'd50;
        tbl[2] = '{a: nom_a, s: 20'd0, c: '0, tot: 0, lat: 2};
        tbl[3] = '{a: alt_a, s: 20'd51, c: '0, tot: 0, lat: 2};
        tbl[4] = '{a: '0, s: 20'd52, c: '0, tot: 50, lat: NOM_LAT};
        tbl[4].a[0] = 16'd30; tbl[4].a[1] = 16'd30; tbl[4].a[2] = 16'd7;
        tbl[4].c[0] = 6'd30; tbl[4].c[1] = 6'd20;

        // Reset state
        #12;
        chk("reset busy", busy, 0);
        chk("reset data_v", data_v, 0);
        chk("reset total", ledTotal, 0);
        chk("reset counts", (LEDCount == '0), 1);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].a, tbl[v].s, -1, '0, gc, gt, lat, bok, pok);
            check_frame($sformatf("vec%0d", v), gc, gt, lat, bok, pok,
                        tbl[v].c, tbl[v].tot, tbl[v].lat);
        end

        // Start while busy is ignored
        run_frame(nom_a, 20'd10536, 50, alt_a, gc, gt, lat, bok, pok);
        check_frame("busy_start", gc, gt, lat, bok, pok, nom_c, 49, NOM_LAT);

        // Reset mid-frame: outputs still hold the nominal frame beforehand
        @(negedge clk);
        amp = tbl[1].a;
        sum = tbl[1].s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst total", ledTotal, 0);
        chk("midrst counts", (LEDCount == '0), 1);
        chk("midrst data_v", data_v, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (data_v) seen++;
        end
        chk("midrst stale data_v", seen, 0);
        run_frame(nom_a, 20'd10536, -1, '0, gc, gt, lat, bok, pok);
        check_frame("after_rst", gc, gt, lat, bok, pok, nom_c, 49, NOM_LAT);

        // Back-to-back with start held high
        @(negedge clk);
        amp = nom_a;
        sum = 20'd10536;
        start = 1'b1;
        seen = 0; dbl = 0; prev_v = 0; cyc = 0;
        while (seen < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (data_v && prev_v) dbl++;
            if (data_v) begin
                tstamp[seen] = cyc;
                seen++;
            end
            prev_v = data_v;
        end
        start = 1'b0;
        chk("b2b frames seen", seen, 3);
        chk("b2b period 1", tstamp[1] - tstamp[0], 207);
        chk("b2b period 2", tstamp[2] - tstamp[1], 207);
        chk("b2b double pulse", dbl, 0);
        chk("b2b total", ledTotal, 49);
        prev = 0;
        while (busy && prev < 400) begin
            @(negedge clk);
            prev++;
        end

        // Randomized frames against the model
        for (int f = 0; f < 15; f++) begin
            amps_t         ra;
            logic [SW-1:0] rs;
            longint        acc;
            acc = 0;
            for (int i = 0; i < BQ; i++) begin
                ra[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : AW'($urandom_range(0, 8000));
                acc += longint'(ra[i]);
            end
            rs = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 2000)) : SW'(acc);
            model(ra, rs, ec, et, el);
            run_frame(ra, rs, -1, '0, gc, gt, lat, bok, pok);
            check_frame($sformatf("rnd%0d", f), gc, gt, lat, bok, pok, ec, et, el);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
